// File: rtl/count_up_down_mod.sv
// Parametrised up/down counter with programmable modulus, step, load/clear and
// registered overflow/underflow pulses. Saturation support is compiled in with `UPDN_SAT_EN.
module count_up_down_mod #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned MAX_VAL = 2**WIDTH - 1,
    parameter int unsigned STEP_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              up_dn,
    input  logic [STEP_W-1:0] step,
    input  logic              clear,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              sat_mode,
    output logic [WIDTH-1:0]  count,
    output logic              ovf,
    output logic              unf,
    output logic              at_max,
    output logic              at_zero
);

    localparam int unsigned CW = WIDTH + 1;
    localparam logic [CW-1:0] MAX_X = CW'(MAX_VAL);
    localparam logic [CW-1:0] MOD_X = CW'(MAX_VAL + 1);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

    logic             sat;
    logic [WIDTH-1:0] count_nxt;
    logic             ovf_nxt;
    logic             unf_nxt;
    logic [CW-1:0]    count_x;
    logic [CW-1:0]    step_x;
    logic [CW-1:0]    sum_up;

`ifdef UPDN_SAT_EN
    assign sat = sat_mode;
`else
    logic unused_sat_mode;
    assign unused_sat_mode = sat_mode;
    assign sat = 1'b0;
`endif

    assign count_x = CW'(count);
    assign step_x  = CW'(step);
    assign sum_up  = count_x + step_x;

    // Next count and flags; clear beats load beats enable.
    always_comb begin
        count_nxt = count;
        ovf_nxt   = 1'b0;
        unf_nxt   = 1'b0;
        if (clear) begin
            count_nxt = '0;
        end else if (load) begin
            count_nxt = (CW'(load_val) > MAX_X) ? MAX_W : load_val;
        end else if (enable && (step != '0)) begin
            if (up_dn) begin
                if (sum_up > MAX_X) begin
                    count_nxt = sat ? MAX_W : WIDTH'(sum_up - MOD_X);
                    ovf_nxt   = 1'b1;
                end else begin
                    count_nxt = WIDTH'(sum_up);
                end
            end else begin
                if (step_x > count_x) begin
                    // Add the modulus first so the intermediate never goes negative.
                    count_nxt = sat ? '0 : WIDTH'(count_x + MOD_X - step_x);
                    unf_nxt   = 1'b1;
                end else begin
                    count_nxt = WIDTH'(count_x - step_x);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            count <= count_nxt;
            ovf   <= ovf_nxt;
            unf   <= unf_nxt;
        end
    end

    assign at_max  = (count == MAX_W);
    assign at_zero = (count == '0);

endmodule

// File: tb/tb_count_up_down_mod.sv
// Directed self-checking bench for count_up_down_mod (WIDTH=4, MAX_VAL=9, STEP_W=2).
// Expectations follow the build: saturating results when UPDN_SAT_EN is defined.
module tb_count_up_down_mod;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       up_dn;
    logic [1:0] step;
    logic       clear;
    logic       load;
    logic [3:0] load_val;
    logic       sat_mode;
    logic [3:0] count;
    logic       ovf;
    logic       unf;
    logic       at_max;
    logic       at_zero;

    int checks   = 0;
    int failures = 0;

    count_up_down_mod #(.WIDTH(4), .MAX_VAL(9), .STEP_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .up_dn(up_dn), .step(step),
        .clear(clear), .load(load), .load_val(load_val), .sat_mode(sat_mode),
        .count(count), .ovf(ovf), .unf(unf), .at_max(at_max), .at_zero(at_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input int c, input int o, input int u);
        check({tag, ".count"}, int'(count), c);
        check({tag, ".ovf"}, int'(ovf), o);
        check({tag, ".unf"}, int'(unf), u);
        check({tag, ".at_max"}, int'(at_max), (c == 9) ? 1 : 0);
        check({tag, ".at_zero"}, int'(at_zero), (c == 0) ? 1 : 0);
    endtask

    task automatic do_load(input logic [3:0] v);
        enable = 1'b0; load = 1'b1; load_val = v;
        tick();
        load = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; up_dn = 1'b1; step = 2'd0; clear = 1'b0;
        load = 1'b0; load_val = 4'd0; sat_mode = 1'b0;
        repeat (2) tick();
        check_state("reset", 0, 0, 0);
        rst_n = 1'b1;

        // Count 1..9,0 with ovf only on the wrap
        enable = 1'b1; up_dn = 1'b1; step = 2'd1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check_state($sformatf("up1_%0d", i), i % 10, (i == 10) ? 1 : 0, 0);
        end

        do_load(4'd8);
        check_state("load8", 8, 0, 0);
        enable = 1'b1; up_dn = 1'b1; step = 2'd3;
        tick();
        check_state("up3_wrap", 1, 1, 0);
        up_dn = 1'b0; step = 2'd2;
        tick();
        check_state("dn2_wrap", 9, 0, 1);
        step = 2'd0;
        tick();
        check_state("step0_hold", 9, 0, 0);
        enable = 1'b0; up_dn = 1'b1; step = 2'd1;
        tick();
        check_state("disabled_hold", 9, 0, 0);

        do_load(4'd13);
        check_state("load_clamp", 9, 0, 0);
        clear = 1'b1; load = 1'b1; enable = 1'b1; load_val = 4'd5; up_dn = 1'b1; step = 2'd3;
        tick();
        check_state("clear_wins", 0, 0, 0);
        clear = 1'b0; load = 1'b1; load_val = 4'd4;
        tick();
        check_state("load_over_en", 4, 0, 0);
        load = 1'b0;

        up_dn = 1'b0; step = 2'd3;
        tick();
        check_state("dn3", 1, 0, 0);
        step = 2'd1;
        tick();
        check_state("dn1_to_zero", 0, 0, 0);
        step = 2'd3;
        tick();
        check_state("dn3_wrap", 7, 0, 1);

        // sat_mode requested: saturates only when the feature is compiled in
        sat_mode = 1'b1;
        do_load(4'd8);
        enable = 1'b1; up_dn = 1'b1; step = 2'd3;
`ifdef UPDN_SAT_EN
        for (int i = 0; i < 3; i++) begin
            tick();
            check_state($sformatf("sat_up_%0d", i), 9, 1, 0);
        end
        do_load(4'd1);
        enable = 1'b1; up_dn = 1'b0; step = 2'd2;
        tick();
        check_state("sat_dn", 0, 0, 1);
        tick();
        check_state("sat_dn_again", 0, 0, 1);
`else
        tick();
        check_state("nosat_up_0", 1, 1, 0);
        tick();
        check_state("nosat_up_1", 4, 0, 0);
        tick();
        check_state("nosat_up_2", 7, 0, 0);
        do_load(4'd1);
        enable = 1'b1; up_dn = 1'b0; step = 2'd2;
        tick();
        check_state("nosat_dn", 9, 0, 1);
`endif
        do_load(4'd6);
        enable = 1'b1; up_dn = 1'b1; step = 2'd3;
        tick();
        check_state("land_on_max", 9, 0, 0);
        sat_mode = 1'b0;

        // Asynchronous reset between edges
        do_load(4'd4);
        enable = 1'b1; up_dn = 1'b1; step = 2'd1;
        tick();
        check_state("pre_reset", 5, 0, 0);
        #3 rst_n = 1'b0;
        #1;
        check_state("async_reset", 0, 0, 0);
        tick();
        check_state("held_reset", 0, 0, 0);
        rst_n = 1'b1;
        tick();
        check_state("post_reset", 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
